// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC owner, single-outstanding imem requester, IF/ID producer.
// Optional FETCH_PERF_EN adds perf_fetched / perf_squashed counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        fetch_valid,
  output logic [31:0] instd,
  output logic [31:0] pcd,
  output logic [31:0] pc4d
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_squashed
`endif
);

  typedef enum logic [1:0] {
    S_RST,
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_q, hold_d;
  logic        drop_q, drop_d;
  logic [31:0] tgt_pc;
  logic [31:0] pc_inc;
  logic [31:0] inst_sel;
  logic        discard;

  assign tgt_pc = redirect_pc & 32'hFFFF_FFFC;
  assign pc_inc = pc_q + 32'd4;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    hold_d      = hold_q;
    drop_d      = drop_q;
    imem_req    = 1'b0;
    fetch_valid = 1'b0;
    inst_sel    = hold_q;
    discard     = 1'b0;
    unique case (state_q)
      S_RST: state_d = S_REQ;
      S_REQ: begin
        imem_req = 1'b1;
        if (redirect) pc_d = tgt_pc;
        if (imem_ready) begin
          state_d = S_WAIT;
          drop_d  = redirect;
        end
      end
      S_WAIT: begin
        inst_sel = imem_rdata;
        if (!imem_rvalid) begin
          if (redirect) begin
            drop_d = 1'b1;
            pc_d   = tgt_pc;
          end
        end else if (drop_q) begin
          drop_d  = 1'b0;
          discard = 1'b1;
          state_d = S_REQ;
          if (redirect) pc_d = tgt_pc;
        end else if (redirect) begin
          discard = 1'b1;
          pc_d    = tgt_pc;
          state_d = S_REQ;
        end else begin
          fetch_valid = 1'b1;
          if (!stall) begin
            pc_d    = pc_inc;
            state_d = S_REQ;
          end else begin
            hold_d  = imem_rdata;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (redirect) begin
          pc_d    = tgt_pc;
          state_d = S_REQ;
        end else begin
          fetch_valid = 1'b1;
          if (!stall) begin
            pc_d    = pc_inc;
            state_d = S_REQ;
          end
        end
      end
      default: state_d = S_RST;
    endcase
  end

  // Address is parked at zero while coming out of reset so every output reads 0.
  assign imem_addr = (state_q == S_RST) ? 32'h0 : pc_q;
  assign instd     = fetch_valid ? inst_sel : 32'h0;
  assign pcd       = fetch_valid ? pc_q : 32'h0;
  assign pc4d      = fetch_valid ? pc_inc : 32'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RST;
      pc_q    <= RESET_PC;
      hold_q  <= 32'h0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      drop_q  <= drop_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetched_q, fetched_d;
  logic [31:0] squashed_q, squashed_d;

  always_comb begin
    fetched_d  = fetched_q;
    squashed_d = squashed_q;
    if (fetch_valid && !stall) fetched_d = fetched_q + 32'd1;
    if (discard) squashed_d = squashed_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetched_q  <= 32'h0;
      squashed_q <= 32'h0;
    end else begin
      fetched_q  <= fetched_d;
      squashed_q <= squashed_d;
    end
  end

  assign perf_fetched  = fetched_q;
  assign perf_squashed = squashed_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus random bench for fetch_unit with a transaction-level
// memory/PC reference model.
module tb_fetch_unit;
  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst, stall, redirect;
  logic [31:0] redirect_pc;
  logic        imem_req, imem_ready, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        fetch_valid;
  logic [31:0] instd, pcd, pc4d;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_squashed;
`endif

  fetch_unit #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .fetch_valid(fetch_valid), .instd(instd),
    .pcd(pcd), .pc4d(pc4d)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_squashed(perf_squashed)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errs = 0;

  // memory model: one pending response, countdown to rvalid
  bit          pend = 0;
  bit          stale = 0;
  int          cnt = 0;
  int          lat = 0;
  logic [31:0] paddr = '0;

  // reference model
  logic [31:0] exp_pc = RPC;
  bit          prev_rst = 0;
  bit          prev_hold = 0;
  bit          exp_fv;
  logic [31:0] exp_fetched = '0;
  logic [31:0] exp_squashed = '0;
  int          idle = 0;

  // values captured at negedge for the edge update
  bit          s_rst, s_req, s_rdy, s_rvalid, s_stall, s_redir, s_fv;
  logic [31:0] s_addr, s_rpc;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0003;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit r, input bit st, input bit rd,
                       input logic [31:0] rp, input bit rdy);
    rst         = r;
    stall       = st;
    redirect    = rd;
    redirect_pc = rp;
    imem_ready  = rdy;
    imem_rvalid = pend && (cnt == 0);
    imem_rdata  = imem_rvalid ? memf(paddr) : $urandom;
    @(negedge clk);
    exp_fv = !redirect &&
             ((imem_rvalid && !stale) || prev_hold);
    if (prev_rst) begin
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_fv", {31'd0, fetch_valid}, 32'd0);
      chk("rst_data", instd | pcd | pc4d, 32'd0);
    end else begin
      chk("fv", {31'd0, fetch_valid}, {31'd0, exp_fv});
      if (imem_req) begin
        chk("addr", imem_addr, exp_pc);
        chk("one_outstanding", {31'd0, pend}, 32'd0);
      end
      if (exp_fv) begin
        chk("pcd", pcd, exp_pc);
        chk("pc4d", pc4d, exp_pc + 32'd4);
        chk("instd", instd, memf(exp_pc));
      end else begin
        chk("idle_data", instd | pcd | pc4d, 32'd0);
      end
    end
    s_rst    = rst;
    s_req    = imem_req;
    s_rdy    = imem_ready;
    s_addr   = imem_addr;
    s_rvalid = imem_rvalid;
    s_stall  = stall;
    s_redir  = redirect;
    s_rpc    = redirect_pc;
    s_fv     = exp_fv;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    if (s_rst) begin
      pend         = 0;
      stale        = 0;
      exp_pc       = RPC;
      prev_rst     = 1;
      prev_hold    = 0;
      exp_fetched  = '0;
      exp_squashed = '0;
      idle         = 0;
    end else begin
      prev_rst = 0;
      if (s_rvalid) begin
        if (stale || s_redir) exp_squashed++;
        pend  = 0;
        stale = 0;
      end else if (pend && cnt > 0) begin
        cnt--;
      end
      if (s_req && s_rdy) begin
        pend  = 1;
        stale = 0;
        paddr = s_addr;
        cnt   = lat;
      end
      if (s_redir && pend) stale = 1;
      prev_hold = s_fv && s_stall;
      if (s_redir) begin
        exp_pc = s_rpc & 32'hFFFF_FFFC;
        idle   = 0;
      end else if (s_fv && !s_stall) begin
        exp_pc = exp_pc + 32'd4;
        exp_fetched++;
        idle   = 0;
      end else begin
        idle++;
        if (idle >= 200) begin
          chk("liveness", 32'(idle), 32'd0);
          idle = 0;
        end
      end
    end
  endtask

  initial begin
    logic [31:0] rp;
    bit          rd;
    // 1: reset, then sequential fetch at zero-wait memory
    lat = 0;
    drive(1, 0, 0, 0, 1); adv();
    drive(1, 0, 0, 0, 1); adv();
    drive(0, 0, 0, 0, 1);
    chk("t1_rst_state_fv", {31'd0, fetch_valid}, 32'd0);
    adv();
    drive(0, 0, 0, 0, 1);
    chk("t1_req0", {31'd0, imem_req}, 32'd1);
    chk("t1_addr0", imem_addr, 32'h100);
    adv();
    drive(0, 0, 0, 0, 1);
    chk("t1_fv0", {31'd0, fetch_valid}, 32'd1);
    chk("t1_pcd0", pcd, 32'h100);
    chk("t1_pc4d0", pc4d, 32'h104);
    adv();
    drive(0, 0, 0, 0, 1);
    chk("t1_addr1", imem_addr, 32'h104);
    adv();
    // 2: stall for 3 cycles as 0x104 returns
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 0, 1);
      chk("t2_fv", {31'd0, fetch_valid}, 32'd1);
      chk("t2_pcd", pcd, 32'h104);
      chk("t2_instd", instd, memf(32'h104));
      chk("t2_noreq", {31'd0, imem_req}, 32'd0);
      adv();
    end
    drive(0, 0, 0, 0, 1);
    chk("t2_release", pcd, 32'h104);
    adv();
    lat = 1;
    drive(0, 0, 0, 0, 1);
    chk("t2_addr", imem_addr, 32'h108);
    adv();
    // 3: redirect while waiting, stale response discarded
    drive(0, 0, 1, 32'h2002, 1);
    chk("t3_fv_redir", {31'd0, fetch_valid}, 32'd0);
    adv();
    lat = 0;
    drive(0, 0, 0, 0, 1);
    chk("t3_fv_drop", {31'd0, fetch_valid}, 32'd0);
    adv();
    drive(0, 0, 0, 0, 1);
    chk("t3_addr", imem_addr, 32'h2000);
    adv();
    // 4: redirect coincident with rvalid
    drive(0, 0, 1, 32'h40, 1);
    chk("t4_fv", {31'd0, fetch_valid}, 32'd0);
    adv();
    drive(0, 0, 0, 0, 1);
    chk("t4_addr", imem_addr, 32'h40);
`ifdef FETCH_PERF_EN
    chk("t4_squashed", perf_squashed, exp_squashed);
`endif
    adv();
    // 5: PC wrap at top of address space
    drive(0, 0, 1, 32'hFFFF_FFFC, 1); adv();
    drive(0, 0, 0, 0, 1);
    chk("t5_addr", imem_addr, 32'hFFFF_FFFC);
    adv();
    drive(0, 0, 0, 0, 1);
    chk("t5_pcd", pcd, 32'hFFFF_FFFC);
    chk("t5_pc4d", pc4d, 32'h0);
    adv();
    lat = 2;
    drive(0, 0, 0, 0, 1);
    chk("t5_addr_wrap", imem_addr, 32'h0);
    adv();
    // 6: reset mid-wait with stall and redirect
    drive(1, 1, 1, 32'h80, 1); adv();
    drive(0, 0, 0, 0, 1);
    chk("t6_req", {31'd0, imem_req}, 32'd0);
    chk("t6_outs", instd | pcd | pc4d, 32'd0);
    adv();
    drive(0, 0, 0, 0, 1);
    chk("t6_addr", imem_addr, RPC);
    adv();
    // random traffic
    for (int i = 0; i < 4000; i++) begin
      lat = $urandom_range(0, 2);
      rd  = !prev_rst && ($urandom_range(0, 9) == 0);
      rp  = ($urandom_range(0, 3) == 0) ?
            (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      drive(0, ($urandom_range(0, 3) == 0), rd, rp,
            ($urandom_range(0, 2) != 0));
      adv();
    end
`ifdef FETCH_PERF_EN
    drive(0, 1, 0, 0, 0);
    chk("perf_fetched", perf_fetched, exp_fetched);
    chk("perf_squashed", perf_squashed, exp_squashed);
    adv();
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
